// File: rtl/downstream_cancel_tracker.sv
// Per-client cancel-rate tracker: windowed, saturating per-client totals and
// counts, with a sticky per-client block flag that only clear or reset releases.
module downstream_cancel_tracker #(
  parameter int               NUM_CLIENTS = 32,
  parameter int               ID_W        = 5,
  parameter int               AMT_W       = 32,
  parameter int               TOT_W       = 32,
  parameter int               CNT_W       = 16,
  parameter logic [TOT_W-1:0] LIMIT       = 'h100,
  parameter int               WINDOW      = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ack,
  input  logic [ID_W-1:0]        client_id,
  input  logic [AMT_W-1:0]       amount,
  input  logic                   clear,
  output logic [TOT_W-1:0]       total_cancel,
  output logic [CNT_W-1:0]       cancelled_orders,
  output logic                   blocked,
  output logic                   saturated,
  output logic                   accepted,
  output logic                   rejected,
  output logic [NUM_CLIENTS-1:0] blocked_mask
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic [WIN_W-1:0]       win_cnt;
  logic                   win_end;
  logic [TOT_W-1:0]       tot [NUM_CLIENTS];
  logic [CNT_W-1:0]       cnt [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] blk;

  logic                   id_ok;
  logic [ID_W-1:0]        sel;
  logic [TOT_W-1:0]       cur_tot;
  logic [CNT_W-1:0]       cur_cnt;
  logic                   cur_blk;
  logic [TOT_W:0]         sum;
  logic [TOT_W-1:0]       new_tot;
  logic [CNT_W-1:0]       new_cnt;
  logic                   new_blk;
  logic                   do_clear;
  logic                   do_ack;
  logic [TOT_W-1:0]       rd_tot;
  logic [CNT_W-1:0]       rd_cnt;
  logic                   rd_blk;

  assign win_end = (win_cnt == WIN_W'(WINDOW - 1));
  assign id_ok   = ({1'b0, client_id} < (ID_W+1)'(NUM_CLIENTS));
  assign sel     = id_ok ? client_id : '0;

  // Entry values as seen after this edge's window clear.
  assign cur_tot = win_end ? '0 : tot[sel];
  assign cur_cnt = win_end ? '0 : cnt[sel];
  assign cur_blk = blk[sel];

  assign sum     = {1'b0, cur_tot} + (TOT_W+1)'(amount);
  assign new_tot = sum[TOT_W] ? '1 : sum[TOT_W-1:0];
  assign new_cnt = (cur_cnt == '1) ? cur_cnt : cur_cnt + CNT_W'(1);
  assign new_blk = (new_tot > LIMIT);

  // ack is fire-and-forget: no back-pressure; exactly one of accepted or
  // rejected pulses on the following cycle to report what happened to it.
  assign do_clear = clear && id_ok;
  assign do_ack   = ack && !clear && id_ok && !cur_blk;

  always_comb begin
    rd_tot = '0;
    rd_cnt = '0;
    rd_blk = 1'b0;
    if (id_ok && !do_clear) begin
      if (do_ack) begin
        rd_tot = new_tot;
        rd_cnt = new_cnt;
        rd_blk = new_blk;
      end else begin
        rd_tot = cur_tot;
        rd_cnt = cur_cnt;
        rd_blk = cur_blk;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt          <= '0;
      blk              <= '0;
      total_cancel     <= '0;
      cancelled_orders <= '0;
      blocked          <= 1'b0;
      saturated        <= 1'b0;
      accepted         <= 1'b0;
      rejected         <= 1'b0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        tot[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      win_cnt <= win_end ? '0 : win_cnt + WIN_W'(1);
      if (win_end) begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
          tot[i] <= '0;
          cnt[i] <= '0;
        end
      end
      // The addressed-entry write follows the window clear so it wins.
      if (do_clear) begin
        tot[sel] <= '0;
        cnt[sel] <= '0;
        blk[sel] <= 1'b0;
      end else if (do_ack) begin
        tot[sel] <= new_tot;
        cnt[sel] <= new_cnt;
        if (new_blk) blk[sel] <= 1'b1;
      end
      total_cancel     <= rd_tot;
      cancelled_orders <= rd_cnt;
      blocked          <= rd_blk;
      saturated        <= (rd_tot == '1) || (rd_cnt == '1);
      accepted         <= do_ack;
      rejected         <= ack && !do_ack;
    end
  end

  assign blocked_mask = blk;

endmodule

// File: tb/tb_downstream_cancel_tracker.sv
// Directed scoreboard bench for downstream_cancel_tracker: default, short-window
// and narrow-total instances share one stimulus stream.
module tb_downstream_cancel_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ack = 1'b0;
  logic        clear = 1'b0;
  logic [4:0]  client_id = '0;
  logic [31:0] amount = '0;

  always #5 clk = ~clk;

  logic [31:0] a_tot;  logic [15:0] a_cnt;  logic a_blk, a_sat, a_acc, a_rej;  logic [31:0] a_mask;
  logic [31:0] w_tot;  logic [15:0] w_cnt;  logic w_blk, w_sat, w_acc, w_rej;  logic [31:0] w_mask;
  logic [7:0]  s_tot;  logic [15:0] s_cnt;  logic s_blk, s_sat, s_acc, s_rej;  logic [19:0] s_mask;

  downstream_cancel_tracker dut_a (
    .clk(clk), .rst(rst), .ack(ack), .client_id(client_id), .amount(amount), .clear(clear),
    .total_cancel(a_tot), .cancelled_orders(a_cnt), .blocked(a_blk), .saturated(a_sat),
    .accepted(a_acc), .rejected(a_rej), .blocked_mask(a_mask)
  );

  downstream_cancel_tracker #(.WINDOW(8)) dut_w (
    .clk(clk), .rst(rst), .ack(ack), .client_id(client_id), .amount(amount), .clear(clear),
    .total_cancel(w_tot), .cancelled_orders(w_cnt), .blocked(w_blk), .saturated(w_sat),
    .accepted(w_acc), .rejected(w_rej), .blocked_mask(w_mask)
  );

  downstream_cancel_tracker #(.NUM_CLIENTS(20), .AMT_W(8), .TOT_W(8), .LIMIT(8'hFF)) dut_s (
    .clk(clk), .rst(rst), .ack(ack), .client_id(client_id), .amount(amount[7:0]), .clear(clear),
    .total_cancel(s_tot), .cancelled_orders(s_cnt), .blocked(s_blk), .saturated(s_sat),
    .accepted(s_acc), .rejected(s_rej), .blocked_mask(s_mask)
  );

  typedef struct packed {
    logic [31:0] tot;
    logic [15:0] cnt;
    logic        blk;
    logic        sat;
    logic        acc;
    logic        rej;
    logic [31:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input logic [31:0] tot, input logic [15:0] cnt, input logic blk,
                          input logic sat, input logic acc, input logic rej, input logic [31:0] mask);
    exp_t e;
    e.tot = tot; e.cnt = cnt; e.blk = blk; e.sat = sat;
    e.acc = acc; e.rej = rej; e.mask = mask;
    exp_q.push_back(e);
  endtask

  task automatic compare(input int sel, input string tag);
    exp_t e;
    logic [31:0] o_tot, o_mask;
    logic [15:0] o_cnt;
    logic o_blk, o_sat, o_acc, o_rej;
    case (sel)
      0:       begin o_tot = a_tot; o_cnt = a_cnt; o_blk = a_blk; o_sat = a_sat;
                     o_acc = a_acc; o_rej = a_rej; o_mask = a_mask; end
      1:       begin o_tot = w_tot; o_cnt = w_cnt; o_blk = w_blk; o_sat = w_sat;
                     o_acc = w_acc; o_rej = w_rej; o_mask = w_mask; end
      default: begin o_tot = {24'h0, s_tot}; o_cnt = s_cnt; o_blk = s_blk; o_sat = s_sat;
                     o_acc = s_acc; o_rej = s_rej; o_mask = {12'h0, s_mask}; end
    endcase
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed output with no expected entry queued", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ".total"}, o_tot, e.tot);
    chk({tag, ".count"}, {16'h0, o_cnt}, {16'h0, e.cnt});
    chk({tag, ".blocked"}, {31'h0, o_blk}, {31'h0, e.blk});
    chk({tag, ".saturated"}, {31'h0, o_sat}, {31'h0, e.sat});
    chk({tag, ".accepted"}, {31'h0, o_acc}, {31'h0, e.acc});
    chk({tag, ".rejected"}, {31'h0, o_rej}, {31'h0, e.rej});
    chk({tag, ".mask"}, o_mask, e.mask);
  endtask

  // Drive one cycle of inputs, queue the expected readout, compare after the edge.
  task automatic step(input int sel, input string tag, input logic a, input logic [4:0] id,
                      input logic [31:0] amt, input logic clr,
                      input logic [31:0] e_tot, input logic [15:0] e_cnt, input logic e_blk,
                      input logic e_sat, input logic e_acc, input logic e_rej, input logic [31:0] e_mask);
    ack = a; client_id = id; amount = amt; clear = clr;
    push_exp(e_tot, e_cnt, e_blk, e_sat, e_acc, e_rej, e_mask);
    @(posedge clk);
    #1;
    compare(sel, tag);
  endtask

  task automatic do_reset(input int sel);
    ack = 1'b0; clear = 1'b0; client_id = '0; amount = '0;
    rst = 1'b1;
    #1;
    push_exp(0, 0, 0, 0, 0, 0, 0);
    compare(sel, "reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Default instance: accumulate, block, clear, readout, exact-limit boundary.
    do_reset(0);
    step(0, "basic",      1, 5'h1B, 32'hC5, 0, 32'hC5,  1, 0, 0, 1, 0, 32'h0);
    step(0, "cross",      1, 5'h1B, 32'hC5, 0, 32'h18A, 2, 1, 0, 1, 0, 32'h0800_0000);
    step(0, "blk_rej",    1, 5'h1B, 32'hC5, 0, 32'h18A, 2, 1, 0, 0, 1, 32'h0800_0000);
    step(0, "clear_ack",  1, 5'h1B, 32'hC5, 1, 32'h0,   0, 0, 0, 0, 1, 32'h0);
    step(0, "post_clear", 1, 5'h1B, 32'h10, 0, 32'h10,  1, 0, 0, 1, 0, 32'h0);
    step(0, "read_05",    0, 5'h05, 32'h77, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0);
    step(0, "read_1b",    0, 5'h1B, 32'h0,  0, 32'h10,  1, 0, 0, 0, 0, 32'h0);
    step(0, "eq_limit",   1, 5'h03, 32'h100, 0, 32'h100, 1, 0, 0, 1, 0, 32'h0);
    step(0, "over_limit", 1, 5'h03, 32'h1,  0, 32'h101, 2, 1, 0, 1, 0, 32'h8);
    step(0, "idle_03",    0, 5'h03, 32'h5,  0, 32'h101, 2, 1, 0, 0, 0, 32'h8);

    // WINDOW=8 instance: rollover restarts the entry, block survives windows.
    do_reset(1);
    for (int k = 0; k < 7; k++)
      step(1, "win_acc", 1, 5'h01, 32'h20, 0, 32'h20 * (k + 1), 16'(k + 1), 0, 0, 1, 0, 32'h0);
    step(1, "win_end_ack", 1, 5'h01, 32'h20, 0, 32'h20, 1, 0, 0, 1, 0, 32'h0);
    step(1, "win_blk",     1, 5'h02, 32'h180, 0, 32'h180, 1, 1, 0, 1, 0, 32'h4);
    for (int k = 0; k < 6; k++)
      step(1, "win_hold", 0, 5'h02, 32'h0, 0, 32'h180, 1, 1, 0, 0, 0, 32'h4);
    step(1, "win_roll",    0, 5'h02, 32'h0,  0, 32'h0, 0, 1, 0, 0, 0, 32'h4);
    step(1, "win_blk_rej", 1, 5'h02, 32'h1,  0, 32'h0, 0, 1, 0, 0, 1, 32'h4);
    step(1, "win_other",   0, 5'h01, 32'h0,  0, 32'h0, 0, 0, 0, 0, 0, 32'h4);

    // TOT_W=8, LIMIT=0xFF, 20 clients: saturation and out-of-range ids.
    do_reset(2);
    step(2, "sat_a",     1, 5'h04, 32'hF0, 0, 32'hF0, 1, 0, 0, 1, 0, 32'h0);
    step(2, "sat_b",     1, 5'h04, 32'h20, 0, 32'hFF, 2, 0, 1, 1, 0, 32'h0);
    step(2, "sat_hold",  1, 5'h04, 32'h01, 0, 32'hFF, 3, 0, 1, 1, 0, 32'h0);
    step(2, "oor_ack",   1, 5'd25, 32'h05, 0, 32'h0,  0, 0, 0, 0, 1, 32'h0);
    step(2, "sat_read",  0, 5'h04, 32'h0,  0, 32'hFF, 3, 0, 1, 0, 0, 32'h0);
    step(2, "sat_clear", 0, 5'h04, 32'h0,  1, 32'h0,  0, 0, 0, 0, 0, 32'h0);

    // Asynchronous reset in the middle of an ack burst.
    do_reset(0);
    for (int k = 0; k < 3; k++)
      step(0, "burst", 1, 5'h07, 32'h3, 0, 32'h3 * (k + 1), 16'(k + 1), 0, 0, 1, 0, 32'h0);
    ack = 1'b1; client_id = 5'h07; amount = 32'h3;
    rst = 1'b1;
    #1;
    push_exp(0, 0, 0, 0, 0, 0, 0);
    compare(0, "async_rst");
    #1;
    rst = 1'b0;
    step(0, "after_rst", 1, 5'h07, 32'h1, 0, 32'h1, 1, 0, 0, 1, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/downstream_cancel_tracker.md
# downstream_cancel_tracker

Parametrised per-client cancel-rate tracker for the downstream path. On every acknowledged cancel it accumulates the cancelled amount and the cancel count into the addressed client's entry, and clears all entries at the end of each rolling time window. It latches a sticky per-client block flag when a client's windowed total exceeds a limit, and rejects further cancels from blocked clients. It is the generalised successor of the single-client `downstream_top` accumulator: parametrised client count and widths, saturating arithmetic, windowing, an explicit clear and a kill-switch.

## Interface
Parameters:
- `NUM_CLIENTS`, 32: number of client entries; must be ≤ 2^ID_W.
- `ID_W`, 5: client id width.
- `AMT_W`, 32: per-cancel amount width.
- `TOT_W`, 32: accumulated total width; must be ≥ AMT_W.
- `CNT_W`, 16: cancel-count width.
- `LIMIT`, 32'h0000_0100: windowed-total block threshold, TOT_W bits.
- `WINDOW`, 1024: window length in cycles; must be ≥ 2.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ack`  in  1  cancel acknowledged for `client_id` this cycle.
- `client_id`  in  ID_W  addressed client, used both for the update and for the readout.
- `amount`  in  AMT_W  cancelled amount; sampled only when `ack`=1.
- `clear`  in  1  zero the `client_id` entry and release its block.
- `total_cancel`  out  TOT_W  windowed total of the readout client.
- `cancelled_orders`  out  CNT_W  windowed cancel count of the readout client.
- `blocked`  out  1  block flag of the readout client.
- `saturated`  out  1  total or count of the readout client is at its maximum value.
- `accepted`  out  1  one-cycle pulse: the previous cycle's `ack` was applied.
- `rejected`  out  1  one-cycle pulse: the previous cycle's `ack` was dropped.
- `blocked_mask`  out  NUM_CLIENTS  all block flags; bit i is client i.

## Operation
State:
- per client: `tot[i]` (TOT_W), `cnt[i]` (CNT_W), `blk[i]`.
- global: `win_cnt`, width clog2(WINDOW).

Each rising edge, applied in this order:
1. **Window.** `win_end` = (`win_cnt` == WINDOW-1). `win_cnt` increments and wraps to 0 after WINDOW-1. On `win_end`, every `tot` and `cnt` is zeroed before step 2. `blk` is never cleared by the window.
2. **Clear.** If `clear`=1 and `client_id` < NUM_CLIENTS: `tot`, `cnt` and `blk` of that client are set to 0. When `clear` is set, `ack` is dropped (`rejected` pulses if `ack`=1).
3. **Ack.** If `ack`=1, `clear`=0, the id is in range and `blk`=0:
   - `tot` ← min(`tot` + `amount`, 2^TOT_W−1), using the post-window value of `tot`.
   - `cnt` ← min(`cnt` + 1, 2^CNT_W−1).
   - `accepted` pulses.
   - If the new `tot` > LIMIT, `blk` is set in the same edge.
   
   An ack for a blocked client or an out-of-range id leaves all state unchanged and pulses `rejected`.
4. **Readout.** Registered outputs take the post-update state of `client_id`, i.e. write-first. An out-of-range `client_id` reads as all zeros.

- Exactly one of `accepted`/`rejected` pulses per `ack`; neither pulses when `ack`=0.
- The block is the kill-switch. It is released only by `clear` or `rst`, and persists across windows.

## Timing
- **Reset.** `rst` asynchronously zeros all state and all outputs immediately: `total_cancel`, `cancelled_orders`, `blocked`, `saturated`, `accepted`, `rejected` and `blocked_mask` are 0, and `win_cnt` is 0. The first edge after release is window cycle 0.
- **Reset mid-operation.** An update in flight is discarded. No partial entry survives.
- **Latency.** 1 cycle. Inputs sampled at edge k are visible on all outputs immediately after edge k and held until edge k+1.
- **Same-client back-to-back acks.** Accepted every cycle with no bubble. Each ack accumulates on the previous result.
- **`ack` at `win_end`.** Counts as the first event of the new window: `tot` = `amount`, `cnt` = 1.
- **`ack` that crosses LIMIT.** Accepted and accumulated. `blocked` rises on the same edge; the next ack is rejected.
- **Total exactly equal to LIMIT.** Does not block.
- **Saturation.** Sticky until the window ends or the entry is cleared; it never wraps.

## Test plan
- **Basic accumulation.** Reset, id 0x1B, ack amount 0xC5 → `total_cancel`=0xC5, `cancelled_orders`=1, `accepted`=1, `blocked`=0.
- **Block on threshold.** Ack 0xC5 again → total 0x18A, count 2, `blocked`=1, `blocked_mask`[27]=1. Third ack 0xC5 → `rejected`=1 and total stays 0x18A.
- **Clear.** Clear+ack on id 0x1B → all 0, `rejected`=1, mask bit 27=0. Next ack 0x10 → total 0x10. Then read id 0x05 → 0, with id 0x1B unaffected.
- **Window rollover (WINDOW=8).** Ack 0x20 on cycles 0..6 gives total 0xE0, count 7. Ack 0x20 on cycle 7 (`win_end`) gives total 0x20, count 1. A previously set `blk` is still 1 after rollover.
- **Saturation (TOT_W=8, LIMIT=0xFF).** Acks of 0xF0 then 0x20 → total 0xFF, `saturated`=1, `blocked`=0 (0xFF does not exceed LIMIT).
- **Asynchronous reset mid-stream.** Assert `rst` between edges during an ack burst → all outputs 0 immediately. After release, the first ack 0x01 → total 0x01, count 1.
